ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 100 ++++++++++
 tb/tb_ram_burst_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams count+1 words from a 2-cycle-latency RAM through a 4-entry FIFO with ready/valid output.
// Ports: clock, reset_n (async active-low); start/base_addr/count request a burst;
//        rdaddress/q talk to the RAM; out_valid/out_ready/out_data/out_last stream the words;
//        busy is high outside IDLE; done pulses once after the final word is accepted.
// Optional: define RAM_BURST_READER_ABORT_EN to add an abort input that cancels a burst without done.
module ram_burst_reader #(
  parameter int bus_width  = 8,
  parameter int addr_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] count,
  output logic [addr_width-1:0] rdaddress,
  input  logic [bus_width-1:0]  q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [bus_width-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef RAM_BURST_READER_ABORT_EN
  ,
  input  logic                  abort
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [addr_width-1:0] remain;
  // p1/p2 track a read one and two cycles after issue; l1/l2 tag the final read
  logic p1, p2, l1, l2;
  logic [bus_width-1:0] mem [4];
  logic [3:0] mem_last;
  logic [1:0] wr, rd;
  logic [2:0] cnt;
  logic issue, final_issue, push, pop, kill, drained;
  // issued-but-unaccepted words bound the FIFO fill, so it can never overflow
  assign issue       = state == RUN && (cnt + {2'b0, p1} + {2'b0, p2}) < 3'd4;
  assign final_issue = issue && remain == '0;
  assign push        = p2;
  assign pop         = out_valid && out_ready;
  // the DRAIN exit is predicted from this cycle's pop so done lands right after the last acceptance
  assign drained     = state == DRAIN && !p1 && !p2 && cnt == {2'b0, pop};
`ifdef RAM_BURST_READER_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign out_valid = cnt != 3'd0;
  assign out_data  = out_valid ? mem[rd] : '0;
  assign out_last  = out_valid && mem_last[rd];
  assign busy      = state != IDLE;
  always_ff @(posedge clock)
    if (push) begin
      mem[wr]      <= q;
      mem_last[wr] <= l2;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      remain    <= '0;
      rdaddress <= '0;
      {p1, p2, l1, l2} <= '0;
      wr        <= '0;
      rd        <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      {p1, p2, l1, l2} <= '0;
      wr    <= '0;
      rd    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= drained;
      p1   <= issue;
      l1   <= final_issue;
      p2   <= p1;
      l2   <= l1;
      if (push) wr <= wr + 2'd1;
      if (pop) rd <= rd + 2'd1;
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
      if (state == IDLE && start) begin
        state     <= RUN;
        rdaddress <= base_addr;
        remain    <= count;
      end
      // the address register keeps the last issued address once the burst has been fully issued
      if (issue) begin
        if (final_issue) state <= DRAIN;
        else begin
          remain    <= remain - 1'b1;
          rdaddress <= rdaddress + 1'b1;
        end
      end
      if (drained) state <= IDLE;
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: randomized directed bench checking ram_burst_reader against a queue-based burst model.
module tb_ram_burst_reader;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] count = '0;
  logic [7:0] rdaddress;
  logic [7:0] q = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic out_last;
  logic busy;
  logic done;
`ifdef RAM_BURST_READER_ABORT_EN
  logic abort = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ram [256];
  logic [7:0] a1 = '0;

  ram_burst_reader #(.bus_width(8), .addr_width(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .rdaddress(rdaddress), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef RAM_BURST_READER_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    a1 <= rdaddress;
    q  <= ram[a1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdaddr"}, rdaddress, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first `stall` cycles
  task automatic run_burst(input logic [7:0] b, input logic [7:0] c, input int mode, input int stall);
    logic [7:0] exp_q[$];
    logic [7:0] a, hold_data, rd_mid;
    logic r, done_exp, hold, finished;
    int first, n_acc;
    for (int i = 0; i <= int'(c); i++) begin
      a = b + 8'(i);
      exp_q.push_back(ram[a]);
    end
    done_exp = 0; hold = 0; finished = 0; first = -1; n_acc = 0; rd_mid = '0; hold_data = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clock);
      start = (cyc == 0);
      if (cyc == 0) begin
        base_addr = b;
        count = c;
      end
      r = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc >= stall);
      out_ready = r;
      chk("done", done, done_exp);
      chk("busy", busy, cyc >= 1 && !done_exp);
      if (done_exp) finished = 1;
      done_exp = 0;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      hold = out_valid && !r;
      hold_data = out_data;
      if (mode == 2 && stall >= 10 && cyc == stall - 5) rd_mid = rdaddress;
      if (mode == 2 && stall >= 10 && cyc == stall - 1) chk("stall_rdaddr", rdaddress, rd_mid);
      if (out_valid && first < 0) first = cyc;
      if (out_valid && r && !finished) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", out_valid, 0);
        end else begin
          chk("data", out_data, exp_q.pop_front());
          chk("last", out_last, exp_q.size() == 0);
          if (mode == 0) chk("consecutive", cyc, first + n_acc);
          n_acc++;
          if (exp_q.size() == 0) done_exp = 1;
        end
      end
    end
    out_ready = 0;
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: burst base %0h count %0h not finished, %0d words left", b, c, exp_q.size());
    end
    if (mode == 0) chk("latency", first, 4);
    chk("rdaddr_end", rdaddress, 8'(b + c));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    #12;
    chk_idle_outputs("reset");
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    chk_idle_outputs("post_reset");
    run_burst(8'h10, 8'd3, 0, 0);
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    run_burst(8'hFE, 8'd3, 0, 0);
    run_burst(8'($urandom), 8'd0, 2, 10);
    run_burst(8'($urandom), 8'd15, 2, 20);
    run_burst(8'($urandom), 8'd15, 1, 0);
    for (int k = 0; k < 4; k++) run_burst(8'($urandom), 8'($urandom_range(0, 20)), 1, 0);
    @(negedge clock);
    start = 1; base_addr = 8'($urandom); count = 8'd7; out_ready = 1;
    @(negedge clock);
    start = 0;
    repeat (5) @(negedge clock);
    reset_n = 0;
    #1;
    chk_idle_outputs("midburst_reset");
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("after_reset_valid", out_valid, 0);
      chk("after_reset_busy", busy, 0);
    end
    run_burst(8'($urandom), 8'd5, 0, 0);
`ifdef RAM_BURST_READER_ABORT_EN
    @(negedge clock);
    start = 1; base_addr = 8'($urandom); count = 8'd7; out_ready = 0;
    @(negedge clock);
    start = 0;
    repeat (5) @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("abort_done", done, 0);
      chk("abort_quiet", out_valid, 0);
    end
    run_burst(8'($urandom), 8'd7, 1, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
